// File: rtl/mult_div_unit_pkg.sv
// Shared MD-class encodings, FSM states and small helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;

  localparam int XLEN = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ops that occupy the unit for several cycles (launched with Start).
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Decoder-side class flag: any instruction that touches HI/LO.
  function automatic logic is_md_class(input logic [3:0] op);
    return (op != MD_NONE) && (op <= MD_MFLO);
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Combinational 32/32 divider: magnitude divide, then sign fix-up (quotient toward zero,
// remainder follows dividend). Divide-by-zero yields zeros; the caller discards them.
module mult_div_unit_divider
  import mult_div_unit_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, q_mag, r_mag;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // 0x80000000 / -1 falls out naturally: magnitude 2^31 / 1, negation wraps back to 0x80000000.
  assign q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
  assign r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);

  assign quo = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem = a_neg ? (~r_mag + 1'b1) : r_mag;

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. The result is computed at launch,
// parked in tHI/tLO, and committed after a fixed Busy window to model iterative latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [3:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   t_hi, t_lo;
  logic              t_wb;

  logic [2*XLEN-1:0] prod_s, prod_u;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   res_hi, res_lo;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{B[XLEN-1]}}, B};
  assign prod_u = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

  mult_div_unit_divider u_div (
    .a         (A),
    .b         (B),
    .is_signed (MDOp == MD_DIV),
    .quo       (quo),
    .rem       (rem)
  );

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (MDOp)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV,
      MD_DIVU:  begin res_hi = rem; res_lo = quo; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      cnt   <= '0;
      t_hi  <= '0;
      t_lo  <= '0;
      t_wb  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start && is_md_start(MDOp)) begin
            t_hi  <= res_hi;
            t_lo  <= res_lo;
            t_wb  <= !(is_div(MDOp) && (B == '0));
            cnt   <= is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            Busy  <= 1'b1;
            state <= RUN;
          end else if (!Start && MDOp == MD_MTHI) begin
            HI <= A;
          end else if (!Start && MDOp == MD_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          // Start/MTHI/MTLO are ignored here; hazard control must not issue them.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (t_wb) begin
              HI <= t_hi;
              LO <= t_lo;
            end
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit: a cycle-level reference model of HI/LO/Busy is
// compared every cycle, and directed scenarios pin the model with literal expectations.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk, reset, Start, Busy;
  logic [3:0]  MDOp;
  logic [31:0] A, B, HI, LO;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_wb = 0;
  int          m_rem = 0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit wb);
    longint p;
    int ia, ib;
    hi = 0; lo = 0; wb = 1;
    case (op)
      MD_MULT:  begin p = longint'(signed'(a)) * longint'(signed'(b)); hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin p = longint'(a) * longint'(b); hi = p[63:32]; lo = p[31:0]; end
      MD_DIV: begin
        if (b == 0) wb = 0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin ia = a; ib = b; lo = ia / ib; hi = ia % ib; end
      end
      MD_DIVU: begin
        if (b == 0) wb = 0;
        else begin lo = a / b; hi = a % b; end
      end
      default: wb = 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic [31:0] rh, rl;
    bit          rw;
    if (!reset) begin
      m_hi <= 0; m_lo <= 0; m_rem <= 0; p_wb <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && p_wb) begin m_hi <= p_hi; m_lo <= p_lo; end
    end else if (Start && (MDOp == MD_MULT || MDOp == MD_MULTU || MDOp == MD_DIV || MDOp == MD_DIVU)) begin
      ref_op(MDOp, A, B, rh, rl, rw);
      p_hi  <= rh; p_lo <= rl; p_wb <= rw;
      m_rem <= (MDOp == MD_MULT || MDOp == MD_MULTU) ? MULT_N : DIV_N;
    end else if (!Start && MDOp == MD_MTHI) m_hi <= A;
    else if (!Start && MDOp == MD_MTLO) m_lo <= A;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("model busy", {31'b0, Busy}, {31'b0, (m_rem > 0)});
    check("model hi", HI, m_hi);
    check("model lo", LO, m_lo);
  end

  task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = s; MDOp = op; A = a; B = b;
    @(negedge clk);
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo);
    int c = 0;
    step(1, op, a, b);
    while (Busy && c < 64) begin c++; step(0, MD_NONE, 0, 0); end
    check({nm, " busy cycles"}, 32'(c), 32'(n));
    check({nm, " hi"}, HI, ehi);
    check({nm, " lo"}, LO, elo);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    Start = 0; MDOp = MD_NONE; A = 0; B = 0; reset = 0;
    repeat (3) step(0, MD_NONE, 0, 0);
    check("reset busy", {31'b0, Busy}, 32'h0);
    check("reset hi", HI, 32'h0);
    check("reset lo", LO, 32'h0);
    reset = 1; chk_en = 1;
    step(0, MD_NONE, 0, 0);

    run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MD_DIVU,  32'd7,         32'd2, DIV_N,  32'd1,         32'd3);

    step(0, MD_MTHI, 32'h11, 0);
    step(0, MD_MTLO, 32'h22, 0);
    check("mthi preload", HI, 32'h11);
    check("mtlo preload", LO, 32'h22);
    run_op("div by zero", MD_DIV, 32'd5, 32'd0, DIV_N, 32'h11, 32'h22);
    run_op("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

    step(0, MD_MTHI, 32'hDEAD_BEEF, 0);
    check("mthi idle hi", HI, 32'hDEAD_BEEF);
    check("mthi idle busy", {31'b0, Busy}, 32'h0);

    // MTLO and a fresh Start land mid-run and must be ignored
    step(1, MD_DIVU, 32'd100, 32'd7);
    c = 0;
    while (Busy && c < 64) begin
      c++;
      if (c == 2) step(0, MD_MTLO, 32'h55, 0);
      else if (c == 3) step(1, MD_MULT, 32'd3, 32'd3);
      else step(0, MD_NONE, 0, 0);
    end
    check("overlap busy cycles", 32'(c), 32'(DIV_N));
    check("overlap hi", HI, 32'd2);
    check("overlap lo", LO, 32'd14);

    run_op("b2b first", MD_MULTU, 32'h0001_0000, 32'h0001_0000, MULT_N, 32'h1, 32'h0);
    step(1, MD_MULT, 32'hFFFF_FFFF, 32'd2);
    check("b2b busy rises", {31'b0, Busy}, 32'h1);
    check("b2b old hi visible", HI, 32'h1);
    check("b2b old lo visible", LO, 32'h0);
    c = 0;
    while (Busy && c < 64) begin c++; step(0, MD_NONE, 0, 0); end
    check("b2b busy cycles", 32'(c), 32'(MULT_N));
    check("b2b hi", HI, 32'hFFFF_FFFF);
    check("b2b lo", LO, 32'hFFFF_FFFE);

    step(1, MD_DIV, 32'd100, 32'd3);
    step(0, MD_NONE, 0, 0);
    step(0, MD_NONE, 0, 0);
    #2 reset = 0;
    #1;
    check("async reset busy", {31'b0, Busy}, 32'h0);
    check("async reset hi", HI, 32'h0);
    check("async reset lo", LO, 32'h0);
    @(negedge clk);
    reset = 1;
    repeat (DIV_N + 2) step(0, MD_NONE, 0, 0);
    check("post reset busy", {31'b0, Busy}, 32'h0);
    check("post reset hi", HI, 32'h0);
    check("post reset lo", LO, 32'h0);

    repeat (4000) begin
      logic [31:0] bv;
      bv = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val();
      step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 9)), rnd_val(), bv);
    end
    repeat (DIV_N + 2) step(0, MD_NONE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
